// File: rtl/glb_bank_arb.sv
// Round-robin arbiter that shares one GLB bank port between NUM_REQ requesters, with burst locking.
// Define GLB_ARB_HOST_PRIO_EN to give requester 0 priority in every idle arbitration.
module glb_bank_arb #(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 64,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 16,
  localparam int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W       = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr_en,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          bank_cen,
  output logic                          bank_wen,
  output logic [ADDR_WIDTH-1:0]         bank_addr,
  output logic [DATA_WIDTH-1:0]         bank_wdata,
  input  logic [DATA_WIDTH-1:0]         bank_rdata,
  output logic [ID_W-1:0]               grant_id,
  output logic                          dbg_state
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]            r_state;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       r_owner;
  logic [ID_W-1:0]       r_grant_id;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic [READ_LATENCY:0] r_tag_v;
  logic [ID_W-1:0]       r_tag_id [READ_LATENCY+1];

  logic [NUM_REQ-1:0]    w_rr_mask;
  logic                  w_host_win;
  logic                  w_win_found;
  logic [ID_W-1:0]       w_win_id;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_id;
  logic [ID_W-1:0]       w_next_ptr;
  logic                  w_accept;
  logic                  w_wr;
  logic                  w_last;
  logic                  w_release;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;

`ifdef GLB_ARB_HOST_PRIO_EN
  assign w_host_win = req_valid[0];
  assign w_rr_mask  = req_valid & ~NUM_REQ'(1);
`else
  assign w_host_win = 1'b0;
  assign w_rr_mask  = req_valid;
`endif

  // Idle winner: first valid requester scanning upward from r_rr_ptr with wrap.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    if (w_host_win) begin
      w_win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
        if (!w_win_found && w_rr_mask[w_idx]) begin
          w_win_found = 1'b1;
          w_win_id    = w_idx;
        end
      end
    end
  end

  // Handshake: a beat transfers on a cycle where req_valid[i] and req_ready[i] are both high;
  // req_ready never depends on the owner's own req_valid while LOCKED.
  always_comb begin
    req_ready = '0;
    if (r_state == LOCKED) req_ready[r_owner] = 1'b1;
    else if (w_win_found)  req_ready[w_win_id] = 1'b1;
  end

  assign w_id       = (r_state == LOCKED) ? r_owner : w_win_id;
  assign w_accept   = |(req_valid & req_ready);
  assign w_wr       = req_wr_en[w_id];
  assign w_last     = req_last[w_id];
  assign w_cnt_inc  = r_beat_cnt + CNT_W'(1);
  assign w_next_ptr = (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + ID_W'(1);
  assign w_release  = w_last || (w_cnt_inc == CNT_W'(MAX_BURST));

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_id == ID_W'(i)) begin
        w_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_grant_id <= '0;
    end else if (w_accept) begin
      r_grant_id <= w_id;
      if (r_state == IDLE) begin
        if (!w_last && (MAX_BURST > 1)) begin
          r_state    <= LOCKED;
          r_owner    <= w_id;
          r_beat_cnt <= CNT_W'(1);
        end else begin
          r_rr_ptr <= w_next_ptr;
        end
      end else if (w_release) begin
        r_state    <= IDLE;
        r_rr_ptr   <= w_next_ptr;
        r_beat_cnt <= '0;
      end else begin
        r_beat_cnt <= w_cnt_inc;
      end
    end
  end

  // Bank command register plus a READ_LATENCY+1 deep tag pipe that lines up with bank_rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_cen   <= 1'b0;
      bank_wen   <= 1'b0;
      bank_addr  <= '0;
      bank_wdata <= '0;
      r_tag_v    <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) r_tag_id[k] <= '0;
    end else begin
      bank_cen <= w_accept;
      if (w_accept) begin
        bank_wen   <= w_wr;
        bank_addr  <= w_addr;
        bank_wdata <= w_wdata;
      end
      r_tag_v     <= {r_tag_v[READ_LATENCY-1:0], w_accept & ~w_wr};
      r_tag_id[0] <= w_id;
      for (int k = 1; k <= READ_LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_tag_v[READ_LATENCY]) rsp_valid[r_tag_id[READ_LATENCY]] = 1'b1;
  end

  assign rsp_rdata = r_tag_v[READ_LATENCY] ? bank_rdata : '0;
  assign grant_id  = w_accept ? w_id : r_grant_id;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_glb_bank_arb.sv
// Bench for glb_bank_arb: directed scenarios plus random traffic against a cycle-level reference model.
module tb_glb_bank_arb;
  localparam int N  = 3;
  localparam int AW = 14;
  localparam int DW = 64;
  localparam int RL = 1;
  localparam int MB = 16;
  localparam int EW = 128;
`ifdef GLB_ARB_HOST_PRIO_EN
  localparam bit HOST_PRIO = 1'b1;
`else
  localparam bit HOST_PRIO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_wr_en, req_last, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, bank_wdata, bank_rdata;
  logic            bank_cen, bank_wen, dbg_state;
  logic [AW-1:0]   bank_addr;
  logic [1:0]      grant_id;

  glb_bank_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_wr_en(req_wr_en), .req_last(req_last),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_cen(bank_cen), .bank_wen(bank_wen), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .grant_id(grant_id), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] bank_val(input logic [AW-1:0] a);
    return {32'hDEADBEEF, 18'h0, a};
  endfunction

  // Bank macro stand-in with one cycle of read latency.
  always_ff @(posedge clk) begin
    if (bank_cen && !bank_wen) bank_rdata <= bank_val(bank_addr);
  end

  // ---------------- reference model / scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit m_locked;
  int m_owner, m_beats, m_ptr, m_grant;
  logic          exp_cen, exp_wen;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
  endtask

  function automatic bit has(input logic [N-1:0] v, input int i);
    logic [N-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic int pick(input logic [N-1:0] v);
    int c;
    if (HOST_PRIO && has(v, 0)) return 0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (!(HOST_PRIO && c == 0) && has(v, c)) return c;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    logic [EW-1:0] e;
    logic [N-1:0]  ev;
    check("bank_cen", 64'(bank_cen), 64'(exp_cen));
    if (exp_cen) begin
      check("bank_wen", 64'(bank_wen), 64'(exp_wen));
      check("bank_addr", 64'(bank_addr), 64'(exp_addr));
      check("bank_wdata", bank_wdata, exp_wdata);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][127:96]) == cyc) begin
      e  = exp_q.pop_front();
      ev = N'(1) << int'(e[95:64]);
      check("rsp_valid", 64'(rsp_valid), 64'(ev));
      check("rsp_rdata", rsp_rdata, e[63:0]);
    end else begin
      check("rsp_idle", 64'(rsp_valid), 64'(0));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] w, input logic [N-1:0] l,
                      input logic [N*AW-1:0] a, input logic [N*DW-1:0] d);
    logic [N-1:0] er;
    int win, id;
    bit acc;
    @(negedge clk);
    check_outputs();
    req_valid = v; req_wr_en = w; req_last = l; req_addr = a; req_wdata = d;
    #1;
    check("state", 64'(dbg_state), 64'(m_locked));
    win = m_locked ? m_owner : pick(v);
    er  = (win >= 0) ? (N'(1) << win) : '0;
    check("ready", 64'(req_ready), 64'(er));
    acc = (win >= 0) && has(v, win);
    id  = acc ? win : m_grant;
    check("grant", 64'(grant_id), 64'(id));
    exp_cen = acc;
    if (acc) begin
      m_grant   = win;
      exp_wen   = has(w, win);
      exp_addr  = AW'(a >> (win * AW));
      exp_wdata = DW'(d >> (win * DW));
      if (!exp_wen) exp_q.push_back({32'(cyc + 1 + RL), 32'(win), bank_val(exp_addr)});
      if (!m_locked) begin
        if (!has(l, win) && MB > 1) begin
          m_locked = 1'b1; m_owner = win; m_beats = 1;
        end else begin
          m_ptr = (win + 1) % N;
        end
      end else begin
        m_beats++;
        if (has(l, win) || m_beats == MB) begin
          m_locked = 1'b0; m_ptr = (m_owner + 1) % N;
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    if (chk) check_outputs();
    reset_n = 1'b0;
    req_valid = '0; req_wr_en = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    #1;
    check("rst_cen", 64'(bank_cen), 64'(0));
    check("rst_wen", 64'(bank_wen), 64'(0));
    check("rst_addr", 64'(bank_addr), 64'(0));
    check("rst_wdata", bank_wdata, 64'(0));
    check("rst_rsp_v", 64'(rsp_valid), 64'(0));
    check("rst_rsp_d", rsp_rdata, 64'(0));
    check("rst_grant", 64'(grant_id), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    check("rst_ready", 64'(req_ready), 64'(0));
    m_locked = 1'b0; m_owner = 0; m_beats = 0; m_ptr = 0; m_grant = 0;
    exp_cen = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc += 3;
  endtask

  function automatic logic [N*AW-1:0] rnd_addr();
    return (N*AW)'({$urandom(), $urandom()});
  endfunction

  function automatic logic [N*DW-1:0] rnd_data();
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < (N*DW + 31) / 32; i++) r = (r << 32) | (N*DW)'($urandom());
    return r;
  endfunction

  function automatic logic [N-1:0] rnd_last();
    logic [N-1:0] r;
    for (int j = 0; j < N; j++) r[j] = ($urandom_range(0, 2) == 0);
    return r;
  endfunction

  // ---------------- stimulus ----------------
  logic [N*AW-1:0] a;

  initial begin
    reset_n = 1'b1;
    req_valid = '0; req_wr_en = '0; req_last = '0; req_addr = '0; req_wdata = '0;
    do_reset(1'b0);

    // All three single-beat readers held: round-robin 0,1,2,0.
    for (int i = 0; i < 4; i++) begin
      step(3'b111, 3'b000, 3'b111, rnd_addr(), rnd_data());
      check("g_rr", 64'(grant_id), 64'(HOST_PRIO ? 0 : i % 3));
    end

    // Requester 1 write burst 0x10..0x13 with neighbours valid, then next grant.
    for (int k = 0; k < 4; k++) begin
      a = rnd_addr();
      a[AW +: AW] = AW'(16 + k);
      step(3'b111, 3'b010, {1'b1, (k == 3), 1'b1}, a, rnd_data());
    end
    step(3'b101, 3'b000, 3'b111, rnd_addr(), rnd_data());
    check("g_after_burst", 64'(grant_id), 64'(HOST_PRIO ? 0 : 2));

    // Requester 0 burst without last: forced release after MAX_BURST beats.
    do_reset(1'b1);
    for (int i = 0; i < 20; i++) begin
      step(3'b011, 3'b000, 3'b010, rnd_addr(), rnd_data());
      check("g_maxburst", 64'(grant_id), 64'((!HOST_PRIO && i == 16) ? 1 : 0));
    end

    // Owner drops valid for three cycles; lock holds.
    do_reset(1'b1);
    step(3'b010, 3'b000, 3'b000, rnd_addr(), rnd_data());
    for (int i = 0; i < 3; i++) begin
      step(3'b001, 3'b000, 3'b001, rnd_addr(), rnd_data());
      check("rdy_hold", 64'(req_ready), 64'(3'b010));
    end
    step(3'b011, 3'b000, 3'b010, rnd_addr(), rnd_data());
    check("g_resume", 64'(grant_id), 64'(1));

    // Read in flight when reset hits: response discarded.
    do_reset(1'b1);
    a = '0;
    a[2*AW +: AW] = AW'(5);
    step(3'b100, 3'b000, 3'b100, a, rnd_data());
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step(3'b000, 3'b000, 3'b000, rnd_addr(), rnd_data());

    // Two continuous single-beat requesters.
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      step(3'b011, 3'b000, 3'b011, rnd_addr(), rnd_data());
      check("g_pair", 64'(grant_id), 64'(HOST_PRIO ? 0 : i % 2));
    end

    // Random traffic with one reset in the middle.
    do_reset(1'b1);
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset(1'b1);
      step(N'($urandom_range(0, 7)), N'($urandom_range(0, 7)), rnd_last(), rnd_addr(), rnd_data());
    end
    for (int i = 0; i < 4; i++) step(3'b000, 3'b000, 3'b000, rnd_addr(), rnd_data());
    check("drain", 64'(exp_q.size()), 64'(0));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
